// File: rtl/if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch unit with a credit-limited request stream,
//               an in-order address queue and a small instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int            PW     = $clog2(BUF_DEPTH);
    localparam int            CW     = 3;
    localparam logic [CW-1:0] c_depth = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] c_last  = PW'(BUF_DEPTH - 1);

    logic [CW-1:0] r_fifo_cnt;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_q_wr_ptr;
    logic [PW-1:0] r_q_rd_ptr;
    logic [31:0]   r_buf_instr [BUF_DEPTH];
    logic [31:0]   r_buf_pc    [BUF_DEPTH];
    logic [31:0]   r_q_addr    [BUF_DEPTH];

    logic [CW:0]   w_inflight;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_rsp_any;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == c_last) ? '0 : p + PW'(1);
    endfunction

    // Every slot in flight or buffered consumes a credit, so a push never overflows.
    assign w_inflight = {1'b0, r_live} + {1'b0, r_discard} + {1'b0, r_fifo_cnt};
    assign imem_req   = rst & ~redirect & (w_inflight < {1'b0, c_depth});
    assign imem_addr  = pc;
    assign w_grant    = imem_req & imem_gnt;
    assign pc_ena     = rst & (redirect | w_grant);

    assign w_rsp_any  = imem_rvalid & ((r_discard != '0) | (r_live != '0));
    assign w_drop     = imem_rvalid & (r_discard != '0);
    assign w_push     = imem_rvalid & (r_discard == '0) & (r_live != '0);

    assign id_valid   = (r_fifo_cnt != '0);
    assign w_pop      = id_valid & id_ready;
    assign id_instr   = id_valid ? r_buf_instr[r_rd_ptr] : '0;
    assign id_pc      = id_valid ? r_buf_pc[r_rd_ptr]    : '0;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (w_grant) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_cnt <= '0;
            r_live     <= '0;
            r_discard  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_q_wr_ptr <= '0;
            r_q_rd_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
                r_q_addr[i]    <= '0;
            end
        end else if (redirect) begin
            // A response landing now is charged to the old stream and dropped.
            r_discard  <= r_discard + r_live - CW'(w_rsp_any);
            r_live     <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_q_wr_ptr <= '0;
            r_q_rd_ptr <= '0;
        end else begin
            if (w_grant) begin
                r_q_addr[r_q_wr_ptr] <= pc;
                r_q_wr_ptr           <= f_inc(r_q_wr_ptr);
            end
            if (w_push) begin
                r_buf_instr[r_wr_ptr] <= imem_rdata;
                r_buf_pc[r_wr_ptr]    <= r_q_addr[r_q_rd_ptr];
                r_wr_ptr              <= f_inc(r_wr_ptr);
                r_q_rd_ptr            <= f_inc(r_q_rd_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            r_live <= r_live + CW'(w_grant) - CW'(w_push);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed and random bench for if_fetch against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    logic        rsp_en;
    int          total = 0;
    int          bad   = 0;

    // reference model state
    logic [63:0] m_buf[$];
    logic [31:0] m_live[$];
    int          m_disc;
    logic [31:0] mem_q[$];

    // values observed by the latest step
    logic        s_req, s_ena, s_valid;
    logic [31:0] s_addr, s_pcn, s_idpc;

    always #5 clk = ~clk;

    if_fetch #(.BUF_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .pc_ena(pc_ena),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, compare against model, advance.
    task automatic step();
        logic        e_req, e_grant, e_ena, e_valid;
        logic [31:0] e_pcn, e_instr, e_idpc, new_pc, a;
        logic [63:0] hd;
        imem_rvalid = rsp_en && (mem_q.size() > 0);
        imem_rdata  = imem_rvalid ? instr_of(mem_q[0]) : 32'h0;
        #1;
        if (!rst) begin
            m_buf.delete();
            m_live.delete();
            m_disc = 0;
        end
        e_req   = rst && !redirect && (m_live.size() + m_disc + m_buf.size() < D);
        e_grant = e_req && imem_gnt;
        e_ena   = rst && (redirect || e_grant);
        e_pcn   = redirect ? redirect_pc : (e_grant ? pc + 32'd4 : pc);
        e_valid = (m_buf.size() > 0);
        hd      = e_valid ? m_buf[0] : 64'h0;
        e_instr = hd[63:32];
        e_idpc  = hd[31:0];

        s_req = imem_req; s_addr = imem_addr; s_ena = pc_ena;
        s_pcn = pc_next;  s_valid = id_valid; s_idpc = id_pc;

        chk("imem_req", imem_req, e_req);
        chk("imem_addr", imem_addr, pc);
        chk("pc_ena", pc_ena, e_ena);
        if (rst) chk("pc_next", pc_next, e_pcn);
        chk("id_valid", id_valid, e_valid);
        chk("id_instr", id_instr, e_instr);
        chk("id_pc", id_pc, e_idpc);

        new_pc = pc;
        if (rst) begin
            if (redirect) begin
                if (imem_rvalid) begin
                    if (m_disc > 0) m_disc--;
                    else if (m_live.size() > 0) void'(m_live.pop_front());
                end
                m_disc += m_live.size();
                m_live.delete();
                m_buf.delete();
                new_pc = redirect_pc;
            end else begin
                if (e_valid && id_ready) void'(m_buf.pop_front());
                if (imem_rvalid) begin
                    if (m_disc > 0) m_disc--;
                    else if (m_live.size() > 0) begin
                        a = m_live.pop_front();
                        m_buf.push_back({imem_rdata, a});
                    end
                end
                if (e_grant) begin
                    m_live.push_back(pc);
                    new_pc = pc + 32'd4;
                end
            end
        end
        if (imem_rvalid) void'(mem_q.pop_front());
        if (e_grant) mem_q.push_back(pc);

        @(posedge clk);
        @(negedge clk);
        pc = new_pc;
        #1;
    endtask

    task automatic do_reset(input logic drain);
        rst = 1'b0; pc = 32'h0; imem_gnt = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; id_ready = 1'b0; rsp_en = drain;
        repeat (3) step();
    endtask

    initial begin
        int  ng;
        bit  found;
        logic [31:0] seq;
        rst = 1'b0; pc = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0; rsp_en = 1'b1; m_disc = 0;
        @(negedge clk);
        #1;

        // reset state and streaming fetch from 0
        do_reset(1'b1);
        rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
        step();
        chk("first_req_after_reset", s_req, 1'b1);
        chk("first_addr_after_reset", s_addr, 32'h0);
        chk("first_grant_pc_ena", s_ena, 1'b1);
        seq = 32'h0;
        for (int i = 0; i < 14; i++) begin
            if (id_valid) begin
                chk("stream_id_pc", id_pc, seq);
                chk("stream_id_instr", id_instr, instr_of(seq));
                seq = seq + 32'd4;
            end
            step();
        end
        chk("stream_progress", (seq >= 32'd16), 1'b1);

        // back-pressure: two grants then stall with entry 0 held
        do_reset(1'b1);
        rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
        ng = 0;
        repeat (6) begin
            step();
            if (s_req && imem_gnt) ng++;
        end
        chk("bp_grants", 32'(ng), 32'd2);
        chk("bp_req_low", s_req, 1'b0);
        chk("bp_valid_held", s_valid, 1'b1);
        chk("bp_idpc_held", s_idpc, 32'h0);
        id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_req) begin found = 1'b1; break; end
        end
        chk("bp_resume_addr", found ? s_addr : 32'hDEAD_BEEF, 32'h8);
        repeat (4) step();

        // redirect with requests 8 and 12 outstanding
        do_reset(1'b1);
        pc = 32'h8; rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b0;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        chk("rd_pc_next", s_pcn, 32'h100);
        chk("rd_pc_ena", s_ena, 1'b1);
        chk("rd_req", s_req, 1'b0);
        redirect = 1'b0; rsp_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_valid) begin found = 1'b1; break; end
        end
        chk("rd_first_idpc", found ? s_idpc : 32'hDEAD_BEEF, 32'h100);

        // redirect coinciding with response and pop
        do_reset(1'b1);
        rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        chk("rv_req", s_req, 1'b0);
        chk("rv_pop_valid", s_valid, 1'b1);
        chk("rv_pc_next", s_pcn, 32'h200);
        redirect = 1'b0;
        step();
        chk("rv_empty_after", s_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid) begin found = 1'b1; break; end
        end
        chk("rv_first_idpc", found ? s_idpc : 32'hDEAD_BEEF, 32'h200);

        // grant withheld for five cycles
        imem_gnt = 1'b0;
        repeat (5) begin
            step();
            chk("nogrant_req", s_req, 1'b1);
            chk("nogrant_ena", s_ena, 1'b0);
            chk("nogrant_pcn", s_pcn, pc);
        end

        // reset mid-transaction with one response outstanding
        do_reset(1'b1);
        rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0; rsp_en = 1'b1;
        step(); step();
        imem_gnt = 1'b0; rsp_en = 1'b0;
        step();
        chk("pre_rst_valid", s_valid, 1'b1);
        rst = 1'b0; pc = 32'h0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_ena", pc_ena, 1'b0);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        step();
        rst = 1'b1; rsp_en = 1'b1;
        step();
        chk("late_rsp_req", s_req, 1'b1);
        step();
        chk("late_rsp_not_pushed", s_valid, 1'b0);

        // random traffic
        do_reset(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            imem_gnt    = ($urandom_range(0, 3) != 0);
            rsp_en      = ($urandom_range(0, 2) != 0);
            id_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
